// File: rtl/input_arbiter_if.sv
// rtl/input_arbiter_if.sv - requester and input-unit handshake signals of input_arbiter
// slave is the arbiter side; master is the requesters plus the input unit.
interface input_arbiter_if #(
  parameter int DW   = 16,
  parameter int NREQ = 2,
  parameter int CW   = 16
);
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] ack_o;
  logic [DW-1:0]   data_o;
  logic [NREQ-1:0] grant_o;
  logic            busy_o;
  logic [CW-1:0]   rd_count_o;
  logic            inp_req;
  logic [DW-1:0]   inp_data;
  logic            inp_ack;

  modport slave (
    input  req_i, inp_data, inp_ack,
    output ack_o, data_o, grant_o, busy_o, rd_count_o, inp_req
  );

  modport master (
    output req_i, inp_data, inp_ack,
    input  ack_o, data_o, grant_o, busy_o, rd_count_o, inp_req
  );
endinterface

// File: rtl/input_arbiter.sv
// rtl/input_arbiter.sv - round-robin sharing of the stdin input unit between requesters
// Four-phase req/ack upstream, one four-phase inp_req/inp_ack transaction downstream per grant.
module input_arbiter #(
  parameter int DW   = 16,
  parameter int NREQ = 2,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input_arbiter_if.slave bus
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW:0] NREQ_W = (LW+1)'(NREQ);

  typedef enum logic [1:0] {IDLE, REQ, DROP, RESP} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_grant;
  logic [DW-1:0]   r_data;
  logic [DW-1:0]   r_data_q;
  logic [CW-1:0]   r_rd_count;
  logic            r_inp_req;
  logic            r_busy;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   r_gidx;

  logic            w_found;
  logic [LW-1:0]   w_sel;
  logic [LW:0]     w_cand;

  // Scan last+1, last+2, ... (mod NREQ); the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, r_last} + (LW+1)'(k);
      if (w_cand >= NREQ_W) begin
        w_cand = w_cand - NREQ_W;
      end
      if (!w_found && bus.req_i[w_cand[LW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[LW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= IDLE;
      r_ack      <= '0;
      r_grant    <= '0;
      r_data     <= '0;
      r_data_q   <= '0;
      r_rd_count <= '0;
      r_inp_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_last     <= LW'(NREQ - 1);
      r_gidx     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant   <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
            r_gidx    <= w_sel;
            r_inp_req <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= REQ;
          end
        end
        // No timeout: the input unit may block on stdin indefinitely.
        REQ: begin
          if (bus.inp_ack) begin
            r_data_q  <= bus.inp_data;
            r_inp_req <= 1'b0;
            r_state   <= DROP;
          end
        end
        DROP: begin
          if (!bus.inp_ack) begin
            if (bus.req_i[r_gidx]) begin
              r_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << r_gidx;
              r_data  <= r_data_q;
              r_state <= RESP;
            end else begin
              r_grant <= '0;
              r_last  <= r_gidx;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        RESP: begin
          if (!bus.req_i[r_gidx]) begin
            r_ack      <= '0;
            r_grant    <= '0;
            r_last     <= r_gidx;
            r_rd_count <= r_rd_count + 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.grant_o    = r_grant;
  assign bus.data_o     = r_data;
  assign bus.busy_o     = r_busy;
  assign bus.rd_count_o = r_rd_count;
  assign bus.inp_req    = r_inp_req;
endmodule

// File: tb/tb_input_arbiter.sv
// tb/tb_input_arbiter.sv - self-checking bench for input_arbiter
// Vector table of request mixes plus hand-written withdraw and mid-transaction reset sequences.
module tb_input_arbiter;
  localparam int DW   = 16;
  localparam int NREQ = 2;
  localparam int CW   = 4;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [DW-1:0]   data;
  } exp_t;

  typedef struct {
    int            n0;
    int            n1;
    int            delay;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int            cnt;
    logic [15:0]   order;
    logic [CW-1:0] exp_rd;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  input_arbiter_if #(.DW(DW), .NREQ(NREQ), .CW(CW)) bus ();

  input_arbiter #(.DW(DW), .NREQ(NREQ), .CW(CW)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic [DW-1:0] inp_vals[$];
  int            remaining[NREQ];
  bit            auto_en   = 1'b1;
  int            inp_delay = 0;
  int            ack_hold  = 0;
  int            n_inp_req = 0;
  bit            saw_ack   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requesters, input-unit model and scoreboard monitor, all stepped on the falling edge.
  initial begin
    logic [NREQ-1:0] prev_ack;
    int              phase;
    int              cnt;
    int              hcnt;
    exp_t            e;
    prev_ack = '0;
    phase    = 0;
    cnt      = 0;
    hcnt     = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        phase       = 0;
        bus.inp_ack = 1'b0;
        prev_ack    = '0;
        continue;
      end
      if (bus.ack_o != '0 && prev_ack == '0) begin
        saw_ack = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_mask", 32'(bus.ack_o), 32'(e.mask));
          check("ack_data", 32'(bus.data_o), 32'(e.data));
          check("ack_grant", 32'(bus.grant_o), 32'(e.mask));
        end
      end
      prev_ack = bus.ack_o;
      case (phase)
        0: if (bus.inp_req) begin
          n_inp_req++;
          if (inp_delay == 0) begin
            bus.inp_data = (inp_vals.size() != 0) ? inp_vals.pop_front() : 16'hDEAD;
            bus.inp_ack  = 1'b1;
            hcnt         = ack_hold;
            phase        = 2;
          end else begin
            cnt   = inp_delay;
            phase = 1;
          end
        end
        1: begin
          cnt--;
          if (cnt == 0) begin
            bus.inp_data = (inp_vals.size() != 0) ? inp_vals.pop_front() : 16'hDEAD;
            bus.inp_ack  = 1'b1;
            hcnt         = ack_hold;
            phase        = 2;
          end
        end
        default: if (!bus.inp_req) begin
          if (hcnt > 0) hcnt--;
          else begin
            bus.inp_ack = 1'b0;
            phase       = 0;
          end
        end
      endcase
      if (auto_en) begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_i[i] && bus.ack_o[i]) begin
            bus.req_i[i] = 1'b0;
            remaining[i]--;
          end else if (!bus.req_i[i] && !bus.ack_o[i] && remaining[i] > 0) begin
            bus.req_i[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    inp_vals.delete();
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    bus.req_i = '0;
    n_inp_req = 0;
    auto_en   = 1'b1;
    inp_delay = 0;
    ack_hold  = 0;
    saw_ack   = 1'b0;
    rst_b     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk);
      #2;
      done = (remaining[0] == 0) && (remaining[1] == 0) && (bus.req_i == '0) &&
             !bus.busy_o && (sb.size() == 0);
    end
    if (!done) check({"timeout_", name}, 32'd1, 32'd0);
  endtask

  task automatic expect_txn(input logic [NREQ-1:0] mask, input logic [DW-1:0] v);
    exp_t e;
    e.mask = mask;
    e.data = v;
    inp_vals.push_back(v);
    sb.push_back(e);
  endtask

  vec_t          vecs[6];
  logic [DW-1:0] v;
  logic [DW-1:0] last_v;
  bit            hit;

  initial begin
    bus.req_i    = '0;
    bus.inp_ack  = 1'b0;
    bus.inp_data = '0;

    vecs[0] = '{1, 0, 0, 16'd1234, 16'd0,  1,  16'h0000, 4'd1};
    vecs[1] = '{1, 1, 2, 16'd7,    16'd2,  2,  16'h0002, 4'd2};
    vecs[2] = '{2, 2, 1, 16'd100,  16'd1,  4,  16'h000A, 4'd4};
    vecs[3] = '{0, 3, 3, 16'd500,  16'd5,  3,  16'h0007, 4'd3};
    vecs[4] = '{8, 8, 0, 16'h1000, 16'h11, 16, 16'hAAAA, 4'd0};
    vecs[5] = '{3, 1, 1, 16'd40,   16'd3,  4,  16'h0002, 4'd4};

    do_reset();
    check("rst_ack",   32'(bus.ack_o),      32'd0);
    check("rst_grant", 32'(bus.grant_o),    32'd0);
    check("rst_data",  32'(bus.data_o),     32'd0);
    check("rst_count", 32'(bus.rd_count_o), 32'd0);
    check("rst_inp",   32'(bus.inp_req),    32'd0);
    check("rst_busy",  32'(bus.busy_o),     32'd0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      inp_delay = vecs[r].delay;
      last_v    = '0;
      for (int k = 0; k < vecs[r].cnt; k++) begin
        v = vecs[r].base + DW'(k) * vecs[r].step;
        expect_txn(vecs[r].order[k] ? 2'b10 : 2'b01, v);
        last_v = v;
      end
      remaining[0] = vecs[r].n0;
      remaining[1] = vecs[r].n1;
      wait_done($sformatf("vec%0d", r));
      check($sformatf("vec%0d_rd_count", r), 32'(bus.rd_count_o), 32'(vecs[r].exp_rd));
      check($sformatf("vec%0d_inp_req_pulses", r), 32'(n_inp_req), 32'(vecs[r].cnt));
      check($sformatf("vec%0d_data_held", r), 32'(bus.data_o), 32'(last_v));
      check($sformatf("vec%0d_grant_idle", r), 32'(bus.grant_o), 32'd0);
      check($sformatf("vec%0d_inp_req_idle", r), 32'(bus.inp_req), 32'd0);
    end

    // Requester 1 withdraws during REQ; the value is dropped and last moves to 1.
    do_reset();
    expect_txn(2'b01, 16'd11);
    remaining[0] = 1;
    wait_done("wd_pre");
    auto_en   = 1'b0;
    inp_delay = 4;
    inp_vals.push_back(16'd555);
    saw_ack   = 1'b0;
    @(posedge clk);
    #1 bus.req_i = 2'b10;
    @(posedge clk);
    #1;
    check("wd_grant_latency", 32'(bus.grant_o), 32'h2);
    check("wd_inp_req",       32'(bus.inp_req), 32'd1);
    check("wd_busy",          32'(bus.busy_o),  32'd1);
    bus.req_i = 2'b00;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      #2 hit = !bus.busy_o;
    end
    check("wd_back_to_idle", 32'(hit), 32'd1);
    check("wd_no_ack",       32'(saw_ack), 32'd0);
    check("wd_rd_count",     32'(bus.rd_count_o), 32'd1);
    check("wd_grant_clear",  32'(bus.grant_o), 32'd0);
    check("wd_inp_pulses",   32'(n_inp_req), 32'd2);
    check("wd_inp_ack_low",  32'(bus.inp_ack), 32'd0);
    inp_delay = 0;
    auto_en   = 1'b1;
    expect_txn(2'b01, 16'd21);
    expect_txn(2'b10, 16'd22);
    remaining[0] = 1;
    remaining[1] = 1;
    wait_done("wd_post");
    check("wd_post_rd_count", 32'(bus.rd_count_o), 32'd3);

    // Reset asserted while the arbiter sits in DROP.
    do_reset();
    expect_txn(2'b01, 16'd77);
    remaining[0] = 1;
    wait_done("rd_pre");
    ack_hold = 3;
    inp_vals.push_back(16'd88);
    remaining[0] = 1;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      #2 hit = !bus.inp_req && bus.inp_ack && bus.busy_o;
    end
    check("rd_reached_drop", 32'(hit), 32'd1);
    check("rd_grant_before", 32'(bus.grant_o), 32'd1);
    rst_b = 1'b0;
    #1;
    check("rd_async_inp_req", 32'(bus.inp_req),    32'd0);
    check("rd_async_ack",     32'(bus.ack_o),      32'd0);
    check("rd_async_grant",   32'(bus.grant_o),    32'd0);
    check("rd_async_count",   32'(bus.rd_count_o), 32'd0);
    check("rd_async_busy",    32'(bus.busy_o),     32'd0);
    check("rd_async_data",    32'(bus.data_o),     32'd0);
    do_reset();
    expect_txn(2'b01, 16'd42);
    remaining[0] = 1;
    wait_done("rd_post");
    check("rd_post_rd_count", 32'(bus.rd_count_o), 32'd1);
    check("rd_post_data",     32'(bus.data_o),     32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/input_arbiter.md
Name: input_arbiter

Overview:
- Shares the single stdin input unit between NREQ requesters, e.g. the CU and a program loader/debug port.
- Upstream, each requester runs a four-phase req/ack handshake with this block.
- Downstream, the block runs one four-phase inp_req/inp_ack transaction with the input unit.
- Sits between the requesters and the input unit; grants are round-robin.

Parameters:
- DW, 16, data width of values read from the input unit
- NREQ, 2, number of requesters (2..8)
- CW, 16, width of completed-read counter

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- req_i  input  NREQ  per-requester read request, level, held until ack
- ack_o  output  NREQ  per-requester acknowledge, at most one bit set
- data_o  output  DW  read value, valid while any ack_o bit is 1
- grant_o  output  NREQ  one-hot owner of current transaction, 0 when idle
- busy_o  output  1  1 whenever state is not IDLE
- rd_count_o  output  CW  completed (acknowledged) reads, wraps modulo 2^CW
- inp_req  output  1  request to input unit
- inp_data  input  DW  value from input unit, valid while inp_ack=1
- inp_ack  input  1  acknowledge from input unit

Behaviour:
- Reset, asynchronous, active-low:
  - State IDLE.
  - ack_o, grant_o, data_o, rd_count_o, inp_req all 0.
  - busy_o = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, REQ, DROP, RESP.
- IDLE:
  - If req_i != 0, select the first set bit scanning last+1, last+2, ... modulo NREQ.
  - Set grant_o to that one-hot bit, set inp_req <= 1, go to REQ.
  - A grant is issued in the cycle after req_i is sampled high.
- REQ:
  - Hold inp_req = 1.
  - On inp_ack = 1: capture data_q <= inp_data, set inp_req <= 0, go to DROP.
  - There is no timeout; the block waits indefinitely, because the input unit blocks on stdin.
- DROP:
  - Wait for inp_ack = 0, which completes the downstream four-phase handshake.
  - If req_i[g] = 1 for granted index g: ack_o[g] <= 1, data_o <= data_q, go to RESP.
  - If req_i[g] = 0 (requester withdrew): the value is discarded, no ack is given, rd_count is unchanged, grant_o <= 0, last <= g, go to IDLE.
- RESP:
  - Hold ack_o[g] = 1 and data_o stable.
  - On req_i[g] = 0: ack_o <= 0, grant_o <= 0, last <= g, rd_count_o <= rd_count_o + 1 (wraps), go to IDLE.
- data_o retains its last value after ack drops.
- Arbitration:
  - Requests from non-granted requesters are ignored until IDLE; they are never lost while held.
  - Simultaneous requests are resolved strictly round-robin from last+1.
- A new grant can start in the cycle IDLE is re-entered, so the minimum gap between transactions is one IDLE cycle.
- req_i changes on non-granted bits during REQ/DROP/RESP have no effect.
- Never asserts inp_req while inp_ack = 1 from a previous transaction: IDLE is reached only after inp_ack = 0 is seen.
- Reset mid-transaction:
  - All outputs clear immediately.
  - The input unit is assumed reset by the same rst_b.
- Latency: downstream handshake time plus 3 cycles, i.e. grant, capture and the ack registers.

Test Plan:
- Single requester 0, input model returns 16'd1234 → grant_o = 01, one inp_req pulse, ack_o = 01 with data_o = 1234 until req_i[0] drops, rd_count_o = 1.
- Both requesters raise req_i = 11 at the same cycle, values 7 then 9 → requester 0 gets 7 first, then requester 1 gets 9; grant order 01, 10; rd_count_o = 2.
- Requester 0 held continuously while requester 1 requests → grants alternate 0, 1, 0, 1 across 4 transactions; no starvation.
- Requester 1 drops req_i during REQ → downstream handshake completes, ack_o never asserts, rd_count_o unchanged, arbiter returns to IDLE with last = 1.
- Assert rst_b = 0 during DROP → inp_req, ack_o, grant_o, rd_count_o = 0 asynchronously; after release, a new request from requester 0 is served normally.
- rd_count_o preset near wrap (CW = 4, 16 reads) → counter wraps to 0 on the 16th ack.
